// File: rtl/scan_pkg.sv
// Shared constants and state type for the decoder scan controller.
package scan_pkg;

    localparam int unsigned N_CH = 8;
    localparam int unsigned X_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan requester and the decoder scan controller.
interface decoder_scan_ctrl_if #(
    parameter int unsigned DIV_W = 16
);
    import scan_pkg::*;

    logic             start;
    logic             stop;
    logic             cont;
    logic [N_CH-1:0]  mask;
    logic [DIV_W-1:0] dwell;
    logic             en;
    logic [X_W-1:0]   x;
    logic             busy;
    logic             wrap;

    modport master (
        output start, stop, cont, mask, dwell,
        input  en, x, busy, wrap
    );

    modport slave (
        input  start, stop, cont, mask, dwell,
        output en, x, busy, wrap
    );

endinterface

// File: rtl/mask_next_sel.sv
// Rotating priority search: first set mask bit strictly above cur, wrapping 7 -> 0.
module mask_next_sel
    import scan_pkg::*;
(
    input  logic [N_CH-1:0] mask,
    input  logic [X_W-1:0]  cur,
    output logic [X_W-1:0]  next,
    output logic            wrapped,
    output logic            none
);

    logic [X_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        next = '0;
        idx  = '0;
        for (int unsigned k = N_CH; k >= 1; k--) begin
            idx = cur + X_W'(k);
            if (mask[idx]) begin
                next = idx;
            end
        end
    end

    assign wrapped = (next <= cur);
    assign none    = (mask == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Steps decoder en/x through the enabled channels with a programmable dwell per channel.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_scan_ctrl_if.slave  bus
);

    scan_state_t      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;

    logic [X_W-1:0]   sel_cur;
    logic [X_W-1:0]   sel_next;
    logic             sel_wrapped;
    logic             sel_none;

    // From IDLE, searching above channel 7 yields the lowest set bit.
    assign sel_cur = (state_q == IDLE) ? X_W'(N_CH - 1) : x_q;

    mask_next_sel u_sel (
        .mask    (bus.mask),
        .cur     (sel_cur),
        .next    (sel_next),
        .wrapped (sel_wrapped),
        .none    (sel_none)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        en_d    = en_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && !sel_none) begin
                    state_d = SCAN;
                    x_d     = sel_next;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = bus.dwell;
                end
            end
            SCAN: begin
                if (bus.stop || (cnt_q == '0 && sel_none)) begin
                    state_d = IDLE;
                    x_d     = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (sel_wrapped && !bus.cont) begin
                    state_d = IDLE;
                    x_d     = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    wrap_d  = 1'b1;
                end else begin
                    x_d    = sel_next;
                    cnt_d  = bus.dwell;
                    wrap_d = sel_wrapped;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.x    = x_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed vector bench for decoder_scan_ctrl: table of per-cycle vectors plus corner sequences.
module tb_decoder_scan_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    decoder_scan_ctrl_if #(.DIV_W(16)) bus ();

    decoder_scan_ctrl #(.DIV_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        cont;
        logic [7:0]  mask;
        logic [15:0] dwell;
        logic        en;
        logic [2:0]  x;
        logic        busy;
        logic        wrap;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic e_en, input logic [2:0] e_x,
                             input logic e_busy, input logic e_wrap);
        check({name, ".en"},   16'(bus.en),   16'(e_en));
        check({name, ".x"},    16'(bus.x),    16'(e_x));
        check({name, ".busy"}, 16'(bus.busy), 16'(e_busy));
        check({name, ".wrap"}, 16'(bus.wrap), 16'(e_wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic s, input logic p, input logic c, input logic [7:0] m,
                          input logic [15:0] d);
        bus.start = s;
        bus.stop  = p;
        bus.cont  = c;
        bus.mask  = m;
        bus.dwell = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);

        // start, stop, cont, mask, dwell | en, x, busy, wrap (after the edge)
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd7, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd2, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd7, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'hA4, 16'd0, 1'b1, 3'd2, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'hA4, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'hA4, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h10, 16'd0, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h10, 16'd0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h10, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0};

        #3;
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_out("idle_after_reset", 1'b0, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].start, tbl[i].stop, tbl[i].cont, tbl[i].mask, tbl[i].dwell);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].x, tbl[i].busy, tbl[i].wrap);
        end

        // Full single sweep, 3 cycles per channel.
        for (int i = 0; i < 24; i++) begin
            set_in(i == 0, 1'b0, 1'b0, 8'hFF, 16'd2);
            tick();
            check_out($sformatf("sweep%0d", i), 1'b1, 3'(i / 3), 1'b1, 1'b0);
        end
        tick();
        check_out("sweep_end", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        check_out("sweep_after", 1'b0, 3'd0, 1'b0, 1'b0);

        // Single enabled channel in continuous mode.
        for (int i = 0; i < 16; i++) begin
            set_in(i == 0, 1'b0, 1'b1, 8'h10, 16'd3);
            tick();
            check_out($sformatf("single%0d", i), 1'b1, 3'd4, 1'b1, (i != 0) && (i % 4 == 0));
        end
        set_in(1'b0, 1'b1, 1'b1, 8'h10, 16'd3);
        tick();
        check_out("single_stop", 1'b0, 3'd0, 1'b0, 1'b0);

        // Abort while channel 3 still has dwell remaining.
        for (int i = 0; i < 10; i++) begin
            set_in(i == 0, 1'b0, 1'b1, 8'hFF, 16'd2);
            tick();
        end
        check_out("abort_pre", 1'b1, 3'd3, 1'b1, 1'b0);
        set_in(1'b0, 1'b1, 1'b1, 8'hFF, 16'd2);
        tick();
        check_out("abort", 1'b0, 3'd0, 1'b0, 1'b0);

        // Mask cleared mid-dwell: channel 0 completes, then idle without wrap.
        set_in(1'b1, 1'b0, 1'b1, 8'hFF, 16'd3);
        tick();
        check_out("mclr_entry", 1'b1, 3'd0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 8'h00, 16'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("mclr_hold%0d", i), 1'b1, 3'd0, 1'b1, 1'b0);
        end
        tick();
        check_out("mclr_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        set_in(1'b1, 1'b0, 1'b1, 8'hFF, 16'd2);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 8'hFF, 16'd2);
        tick();
        tick();
        tick();
        check_out("arst_pre", 1'b1, 3'd1, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("arst", 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_out("arst_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
